// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback-port bundle shared by the pipeline, the MDU and the
//               register file write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  logic          pipe_we;
  logic [AW-1:0] pipe_wa;
  logic [DW-1:0] pipe_wd;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_wa;
  logic [DW-1:0] mdu_wd;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [31:0]   busy;
  logic          stall_req;

  // Arbiter side
  modport slave (
    input  pipe_we, pipe_wa, pipe_wd, mdu_valid, mdu_wa, mdu_wd,
    output mdu_ready, we3, wa3, wd3, busy, stall_req
  );

  // Pipeline/MDU/regfile side
  modport master (
    output pipe_we, pipe_wa, pipe_wd, mdu_valid, mdu_wa, mdu_wd,
    input  mdu_ready, we3, wa3, wd3, busy, stall_req
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the regfile write port between pipeline writeback
//               (priority, zero latency) and a FIFO of queued MDU results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DW         = 64,
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  wire                   clk,
  input  wire                   reset,
  regfile_wb_arbiter_if.slave   wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] c_XZR    = AW'(31);
  localparam logic [CW-1:0] c_FULL   = CW'(DEPTH);
  localparam logic [SW-1:0] c_STARVE = SW'(STARVE_MAX);

  logic [AW-1:0]    r_wa [DEPTH];
  logic [DW-1:0]    r_wd [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  logic             r_stall;

  logic             w_pe;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_vld_next;
  logic [CW-1:0]    w_count_next;
  logic [SW-1:0]    w_starve_next;
  logic             w_stall_next;
  logic [31:0]      w_busy;

  assign w_pe    = wb.pipe_we && (wb.pipe_wa != c_XZR);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  assign w_push  = wb.mdu_valid && !w_full && (wb.mdu_wa != c_XZR);
  assign w_pop   = !w_pe && !w_empty;

  assign wb.mdu_ready = !w_full;
  assign wb.we3       = w_pe || !w_empty;
  assign wb.wa3       = w_pe ? wb.pipe_wa : (w_empty ? '0 : r_wa[r_rd_ptr]);
  assign wb.wd3       = w_pe ? wb.pipe_wd : (w_empty ? '0 : r_wd[r_rd_ptr]);
  assign wb.busy      = w_busy;
  assign wb.stall_req = r_stall;

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_busy = w_busy | (32'(1) << r_wa[i]);
    end
    w_busy[31] = 1'b0;
  end

  always_comb begin
    w_vld_next = r_vld;
    if (w_pop)  w_vld_next[r_rd_ptr] = 1'b0;
    if (w_push) w_vld_next[r_wr_ptr] = 1'b1;

    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_next = r_count - CW'(1);
  end

  // Starvation only accrues while an entry waits behind a pipeline write;
  // the stall flag rises on the edge where the counter hits its limit.
  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || w_empty)                w_starve_next = '0;
    else if (w_pe && r_starve != c_STARVE) w_starve_next = r_starve + SW'(1);

    w_stall_next = w_pop ? 1'b0 : (r_stall || (w_starve_next == c_STARVE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= w_count_next;
      r_vld    <= w_vld_next;
      r_starve <= w_starve_next;
      r_stall  <= w_stall_next;
    end
  end

  // Payload storage needs no reset; validity is tracked by r_vld/r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wa[r_wr_ptr] <= wb.mdu_wa;
      r_wd[r_wr_ptr] <= wb.mdu_wd;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed scoreboard bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  wa;
    logic [63:0] wd;
  } exp_t;

  exp_t q[$];

  regfile_wb_arbiter_if #(.DW(64), .AW(5)) wb ();

  regfile_wb_arbiter #(.DW(64), .AW(5), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pwa, input logic [63:0] pwd,
                       input logic mv, input logic [4:0] mwa, input logic [63:0] mwd);
    wb.pipe_we   = pwe;
    wb.pipe_wa   = pwa;
    wb.pipe_wd   = pwd;
    wb.mdu_valid = mv;
    wb.mdu_wa    = mwa;
    wb.mdu_wd    = mwd;
  endtask

  task automatic expect_wr(input logic [4:0] wa, input logic [63:0] wd);
    exp_t e;
    e.cyc = cyc;
    e.wa  = wa;
    e.wd  = wd;
    q.push_back(e);
  endtask

  // Monitor: every regfile write must match the next scheduled expectation
  always @(negedge clk) begin
    if (wb.we3 === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got wa=%0d wd=0x%0h, expected no write (cycle %0d)",
                 wb.wa3, wb.wd3, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.wa !== wb.wa3 || e.wd !== wb.wd3) begin
          n_fail++;
          $display("FAIL write: got cycle %0d wa=%0d wd=0x%0h, expected cycle %0d wa=%0d wd=0x%0h",
                   cyc, wb.wa3, wb.wd3, e.cyc, e.wa, e.wd);
        end
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_write: got we3=0, expected wa=%0d wd=0x%0h (cycle %0d)",
               q[0].wa, q[0].wd, cyc);
      void'(q.pop_front());
    end
  end

  initial begin
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_busy", 64'(wb.busy), 64'd0);
    chk("reset_ready", 64'(wb.mdu_ready), 64'd1);
    chk("reset_stall", 64'(wb.stall_req), 64'd0);
    chk("reset_we3", 64'(wb.we3), 64'd0);

    // Pipeline passthrough, then XZR write suppressed
    drive(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd5, 64'hAA);
    #1 chk("pipe_wa3", 64'(wb.wa3), 64'd5);
    step();
    drive(1'b1, 5'd31, 64'h55, 1'b0, 5'd0, 64'd0);
    #1 chk("pipe_xzr_we3", 64'(wb.we3), 64'd0);
    step();

    // MDU idle drain
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h1234);
    #1 chk("mdu_ready_idle", 64'(wb.mdu_ready), 64'd1);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd7, 64'h1234);
    #1 chk("busy7_set", 64'(wb.busy), 64'h80);
    step();
    chk("busy7_clr", 64'(wb.busy), 64'd0);

    // Priority and full
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd8, 64'h80);
    expect_wr(5'd1, 64'h11);
    step();
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd9, 64'h90);
    expect_wr(5'd1, 64'h11);
    #1 chk("ready_cnt1", 64'(wb.mdu_ready), 64'd1);
    chk("busy_8", 64'(wb.busy), 64'h100);
    step();
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd10, 64'hA0);
    expect_wr(5'd1, 64'h11);
    #1 chk("ready_full", 64'(wb.mdu_ready), 64'd0);
    chk("busy_8_9", 64'(wb.busy), 64'h300);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd8, 64'h80);
    step();
    expect_wr(5'd9, 64'h90);
    step();
    chk("busy_drained", 64'(wb.busy), 64'd0);
    chk("ready_drained", 64'(wb.mdu_ready), 64'd1);

    // Starvation
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 64'hC0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 64'd0);
      expect_wr(5'd2, 64'h22);
      #1 chk("stall_low", 64'(wb.stall_req), 64'd0);
      step();
    end
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd12, 64'hC0);
    #1 chk("stall_high", 64'(wb.stall_req), 64'd1);
    step();
    chk("stall_cleared", 64'(wb.stall_req), 64'd0);

    // Simultaneous push and pop at count 1
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd13, 64'hD0);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd14, 64'hE0);
    expect_wr(5'd13, 64'hD0);
    #1 chk("pushpop_ready", 64'(wb.mdu_ready), 64'd1);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd14, 64'hE0);
    #1 chk("pushpop_busy", 64'(wb.busy), 64'h4000);
    chk("pushpop_ready2", 64'(wb.mdu_ready), 64'd1);
    step();
    chk("pushpop_busy_clr", 64'(wb.busy), 64'd0);

    // MDU beat to XZR is accepted but never queued
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hF0);
    #1 chk("xzr_ready", 64'(wb.mdu_ready), 64'd1);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1 chk("xzr_busy", 64'(wb.busy), 64'd0);
    step();

    // Reset with a full FIFO and stall asserted
    drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd20, 64'h200);
    expect_wr(5'd3, 64'h33);
    step();
    drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd21, 64'h210);
    expect_wr(5'd3, 64'h33);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0);
      expect_wr(5'd3, 64'h33);
      step();
    end
    chk("pre_rst_stall", 64'(wb.stall_req), 64'd1);
    chk("pre_rst_ready", 64'(wb.mdu_ready), 64'd0);
    chk("pre_rst_busy", 64'(wb.busy), 64'h300000);
    reset = 1'b1;
    expect_wr(5'd3, 64'h33);
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1;
    chk("post_rst_busy", 64'(wb.busy), 64'd0);
    chk("post_rst_ready", 64'(wb.mdu_ready), 64'd1);
    chk("post_rst_stall", 64'(wb.stall_req), 64'd0);
    chk("post_rst_we3", 64'(wb.we3), 64'd0);
    repeat (3) step();

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
